// File: rtl/alu_result_buffer.sv
// alu_result_buffer: queues signed ALU results in a show-ahead FIFO with flag tagging and a sticky overflow.
// Define ALU_RES_STATS_EN to build the saturating drop counter; otherwise drop_cnt is tied to zero.
module alu_result_buffer #(
    parameter int OUTPUT_WIDTH = 6,
    parameter int DEPTH        = 4,
    parameter int MAXPOSOP     = 30,
    parameter int MAXNEGOP     = -30,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [OUTPUT_WIDTH-1:0]      in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUTPUT_WIDTH-1:0]      out_data,
    output logic [2:0]                   out_flags,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         ovf,
    input  logic                         ovf_clr,
    output logic [CNT_WIDTH-1:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [OUTPUT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & ((level < LW'(DEPTH)) | pop);
    assign drop      = in_valid & ~push;
    assign out_valid = level != '0;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        out_flags[0] = out_data == '0;
        out_flags[1] = out_data[OUTPUT_WIDTH-1];
        out_flags[2] = (out_data == OUTPUT_WIDTH'(MAXPOSOP)) | (out_data == OUTPUT_WIDTH'(MAXNEGOP));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            level  <= level + LW'(push) - LW'(pop);
            ovf    <= drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
        end
    end

`ifdef ALU_RES_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (ovf_clr)
            drop_cnt <= CNT_WIDTH'(drop);
        else if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign drop_cnt = '0;
`endif
endmodule
